muldiv_unit: RTL

// Iterative multiply/divide unit that owns the HI/LO registers.
// It sits directly downstream of the register file read ports:
//   - srca is driven from read port 1 (rs), srcb from read port 2 (rt).
//   - It executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles.
// The pipeline reads results through hi/lo (MFHI/MFLO), stalls on busy,
// and loads HI/LO directly via MTHI/MTLO.

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide over WIDTH iterations, with a final sign-fix cycle and MTHI/MTLO loads.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hiwen,
  input  logic             lowen,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state_r, next_state_s;

  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH:0]   work_r, step_s;
  logic [WIDTH-1:0]   opb_r, srca_r, hi_r, lo_r;
  logic               op_div_r, sign_a_r, sign_b_r, busy_r, done_r;
  logic               sign_a_s, sign_b_s, ge_s;
  logic [WIDTH-1:0]   a_abs_s, b_abs_s, quo_s, rem_s, res_hi_s, res_lo_s;
  logic [WIDTH:0]     sum_s, shifted_s, diff_s;
  logic [2*WIDTH-1:0] prod_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_CALC;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          next_state_s = S_FINISH;
        end else begin
          next_state_s = S_CALC;
        end
      end
      S_FINISH: next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Operand magnitudes; only signed ops (op[0]==0) look at the sign bits
  always_comb begin
    sign_a_s = ~op[0] & srca[WIDTH-1];
    sign_b_s = ~op[0] & srcb[WIDTH-1];
    a_abs_s  = sign_a_s ? -srca : srca;
    b_abs_s  = sign_b_s ? -srcb : srcb;
  end

  // One iteration: work_r holds {upper acc/remainder, multiplier/quotient bits}
  always_comb begin
    sum_s     = work_r[0] ? (work_r[2*WIDTH:WIDTH] + {1'b0, opb_r}) : work_r[2*WIDTH:WIDTH];
    shifted_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
    ge_s      = (shifted_s >= {1'b0, opb_r});
    diff_s    = shifted_s - {1'b0, opb_r};
    if (op_div_r) begin
      if (ge_s) begin
        step_s = {diff_s, work_r[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {shifted_s, work_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {1'b0, sum_s, work_r[WIDTH-1:1]};
    end
  end

  // Sign fix and divide-by-zero handling; most-negative / -1 falls out naturally
  always_comb begin
    quo_s = work_r[WIDTH-1:0];
    rem_s = work_r[2*WIDTH-1:WIDTH];
    if (sign_a_r ^ sign_b_r) begin
      prod_s = -work_r[2*WIDTH-1:0];
    end else begin
      prod_s = work_r[2*WIDTH-1:0];
    end
    if (!op_div_r) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end else if (opb_r == '0) begin
      res_hi_s = srca_r;
      res_lo_s = '1;
    end else begin
      res_lo_s = (sign_a_r ^ sign_b_r) ? -quo_s : quo_s;
      res_hi_s = sign_a_r ? -rem_s : rem_s;
    end
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      work_r   <= '0;
      opb_r    <= '0;
      srca_r   <= '0;
      op_div_r <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (next_state_s != S_IDLE);
      done_r <= (state_r == S_FINISH);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_div_r <= op[1];
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            srca_r   <= srca;
            opb_r    <= b_abs_s;
            work_r   <= {{(WIDTH + 1){1'b0}}, a_abs_s};
            cnt_r    <= '0;
          end else begin
            if (hiwen) begin
              hi_r <= srca;
            end
            if (lowen) begin
              lo_r <= srca;
            end
          end
        end
        S_CALC: begin
          work_r <= step_s;
          cnt_r  <= cnt_r + CNT_W'(1);
        end
        S_FINISH: begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
